// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Round-robin arbiter sharing the register-file write port among
//             writeback requesters, plus a per-register busy scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_rd_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic                        rf_write_enable,
    output logic [ADDR_W-1:0]           rf_rd_addr,
    output logic [DATA_W-1:0]           rf_data_in,
    input  logic                        reserve_valid,
    input  logic [ADDR_W-1:0]           reserve_rd,
    input  logic [ADDR_W-1:0]           rs1_addr,
    input  logic [ADDR_W-1:0]           rs2_addr,
    output logic                        rs1_busy,
    output logic                        rs2_busy,
    output logic [(2**ADDR_W)-1:0]      busy_vec
);

    localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NUM_REGS = 2**ADDR_W;

    logic [PTR_W-1:0]     r_rr_ptr;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_rd;
    logic [DATA_W-1:0]    r_data;
    logic [NUM_REGS-1:0]  r_busy;

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [NUM_REQ-1:0]   w_grant;
    logic [PTR_W-1:0]     w_winner;
    logic                 w_xfer;
    logic [ADDR_W-1:0]    w_sel_rd;
    logic [DATA_W-1:0]    w_sel_data;
    logic [PTR_W-1:0]     w_ptr_nxt;
    logic [NUM_REGS-1:0]  w_set;
    logic [NUM_REGS-1:0]  w_clr;
    logic [NUM_REGS-1:0]  w_busy_nxt;

    // Rotate the request vector so that position 0 is the current priority
    // holder; the first set bit of the rotated view is the winner's offset.
    always_comb begin
        int sum;
        sum      = 0;
        w_dbl    = {req_valid, req_valid} >> r_rr_ptr;
        w_rot    = w_dbl[NUM_REQ-1:0];
        w_xfer   = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_xfer && w_rot[k]) begin
                w_xfer = 1'b1;
                sum    = int'(r_rr_ptr) + k;
                if (sum >= NUM_REQ) begin
                    sum = sum - NUM_REQ;
                end
                w_winner = PTR_W'(sum);
            end
        end
        if (rst) begin
            w_xfer = 1'b0;
        end
    end

    always_comb begin
        w_grant    = '0;
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_grant[i] = w_xfer && (w_winner == PTR_W'(i));
            if (w_grant[i]) begin
                w_sel_rd   = req_rd_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign req_ready = w_grant;
    assign w_ptr_nxt = (w_winner == PTR_W'(NUM_REQ-1)) ? '0 : w_winner + PTR_W'(1);

    // Set is applied after clear so a new producer claiming the register in
    // the same cycle as the old producer's writeback keeps it busy.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (reserve_valid && (reserve_rd != '0)) begin
            w_set[reserve_rd] = 1'b1;
        end
        if (w_xfer && (w_sel_rd != '0)) begin
            w_clr[w_sel_rd] = 1'b1;
        end
        w_busy_nxt    = (r_busy & ~w_clr) | w_set;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_busy   <= '0;
            r_we     <= 1'b0;
            r_rd     <= '0;
            r_data   <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_we   <= w_xfer && (w_sel_rd != '0);
            if (w_xfer) begin
                r_rr_ptr <= w_ptr_nxt;
                r_rd     <= w_sel_rd;
                r_data   <= w_sel_data;
            end
        end
    end

    // A pending writeback is suppressed while reset is held so that the
    // register file never commits a write on the reset edge.
    assign rf_write_enable = r_we & ~rst;
    assign rf_rd_addr      = r_rd;
    assign rf_data_in      = r_data;
    assign busy_vec        = r_busy;
    assign rs1_busy        = r_busy[rs1_addr];
    assign rs2_busy        = r_busy[rs2_addr];

endmodule
`default_nettype wire
